// File: rtl/l2_victim_buffer.sv
`default_nettype none
// ============================================================================
// l2_victim_buffer: 4-entry fully associative victim / write-back buffer
// between the L2 physical-memory port and physical memory.  Rev 1.0
// ============================================================================
module l2_victim_buffer #(
   parameter int width   = 256,
   parameter int entries = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             l2_pmem_read,
   input  logic             l2_pmem_write,
   input  logic [15:0]      l2_pmem_address,
   input  logic [width-1:0] l2_pmem_wdata,
   output logic [width-1:0] l2_pmem_rdata,
   output logic             l2_pmem_resp,
   output logic             dirty_from_vc,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic [15:0]      pmem_address,
   output logic [width-1:0] pmem_wdata,
   input  logic [width-1:0] pmem_rdata,
   input  logic             pmem_resp
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_READ_HIT  = 3'd1,
      S_FETCH     = 3'd2,
      S_WRITEBACK = 3'd3,
      S_INSERT    = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [entries-1:0] valid_q;
   logic [10:0]        tag_q  [entries];
   logic [width-1:0]   data_q [entries];
   logic [1:0]         rptr_q;
   logic [1:0]         hit_idx_q;

   logic               hit;
   logic [1:0]         hit_idx;
   logic               free_any;
   logic [1:0]         free_idx;
   logic [1:0]         ins_idx;
   logic [10:0]        req_tag;
   logic               unused_addr_bits;

   assign req_tag          = l2_pmem_address[15:5];
   assign unused_addr_bits = ^l2_pmem_address[4:0];

   // At most one valid entry can carry a given tag, so the last match wins safely.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = 2'd0;
      free_any = 1'b0;
      free_idx = 2'd0;
      for (int i = 0; i < entries; i++) begin
         if (valid_q[i] && (tag_q[i] == req_tag)) begin
            hit     = 1'b1;
            hit_idx = 2'(i);
         end
      end
      for (int i = entries - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_any = 1'b1;
            free_idx = 2'(i);
         end
      end
   end

   assign ins_idx = hit ? hit_idx : free_idx;

   always_comb begin
      state_d       = state_q;
      l2_pmem_rdata = '0;
      l2_pmem_resp  = 1'b0;
      dirty_from_vc = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_address  = 16'h0000;
      pmem_wdata    = '0;
      case (state_q)
         S_IDLE: begin
            if (l2_pmem_read) begin
               state_d = hit ? S_READ_HIT : S_FETCH;
            end else if (l2_pmem_write) begin
               state_d = (hit || free_any) ? S_INSERT : S_WRITEBACK;
            end
         end
         S_READ_HIT: begin
            l2_pmem_resp  = 1'b1;
            l2_pmem_rdata = data_q[hit_idx_q];
            dirty_from_vc = 1'b1;
            state_d       = S_DONE;
         end
         S_FETCH: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, 5'b00000};
            if (pmem_resp) begin
               l2_pmem_resp  = 1'b1;
               l2_pmem_rdata = pmem_rdata;
               state_d       = S_DONE;
            end
         end
         S_WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q[rptr_q], 5'b00000};
            pmem_wdata   = data_q[rptr_q];
            if (pmem_resp) begin
               state_d = S_INSERT;
            end
         end
         S_INSERT: begin
            l2_pmem_resp = 1'b1;
            state_d      = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         valid_q   <= '0;
         rptr_q    <= 2'd0;
         hit_idx_q <= 2'd0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (l2_pmem_read && hit) begin
                  hit_idx_q <= hit_idx;
               end
            end
            // Swapping the line back to L2 frees the entry; L2 now owns it dirty.
            S_READ_HIT: begin
               valid_q[hit_idx_q] <= 1'b0;
            end
            S_WRITEBACK: begin
               if (pmem_resp) begin
                  valid_q[rptr_q] <= 1'b0;
                  rptr_q          <= rptr_q + 2'd1;
               end
            end
            S_INSERT: begin
               valid_q[ins_idx] <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_INSERT) begin
         tag_q[ins_idx]  <= req_tag;
         data_q[ins_idx] <= l2_pmem_wdata;
      end
   end

endmodule
`default_nettype wire
